// File: rtl/mm_pkg.sv
// Shared matrix-multiply datapath definitions: default vector geometry and
// the packer state encoding.
package mm_pkg;

    localparam int unsigned DEFAULT_N    = 32;
    localparam int unsigned DEFAULT_BITS = 32;

    typedef enum logic {
        S_FILL,
        S_HOLD
    } packer_state_t;

endpackage

// File: rtl/vec_packer.sv
// Serial-to-parallel packer: N BITS-wide beats -> one N*BITS vector, lane k at [k*BITS +: BITS].
// Optional VEC_PACKER_PAD_EN: in_last closes a short vector with zero-padded upper lanes.
module vec_packer
    import mm_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_N,
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS-1:0]        in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N*BITS-1:0]      out_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N+1)-1:0] out_count
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    packer_state_t          state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N-1:0][BITS-1:0] fill_q, fill_d;
    logic [N-1:0][BITS-1:0] vec_q, vec_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   accept;
    logic                   close;

    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_vec   = vec_q;
    assign out_count = count_q;

`ifdef VEC_PACKER_PAD_EN
    assign close = accept && ((idx_q == IW'(N - 1)) || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign close = accept && (idx_q == IW'(N - 1));
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        vec_d   = vec_q;
        count_d = count_q;

        if (accept) begin
            fill_d[idx_q] = in_data;
            idx_d         = idx_q + IW'(1);
        end

        if (out_valid && out_ready) begin
            state_d = S_FILL;
        end

        // Completing beat bypasses the fill register; lanes above it are zeroed for short rows.
        if (close) begin
            idx_d   = '0;
            count_d = CW'(idx_q) + CW'(1);
            state_d = S_HOLD;
            for (int k = 0; k < int'(N); k++) begin
                if (k == int'(idx_q)) begin
                    vec_d[k] = in_data;
                end else if (k < int'(idx_q)) begin
                    vec_d[k] = fill_q[k];
                end else begin
                    vec_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            idx_q   <= '0;
            fill_q  <= '0;
            vec_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            vec_q   <= vec_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_vec_packer.sv
// Directed bench for vec_packer (N=32, BITS=32); pad expectations follow VEC_PACKER_PAD_EN.
module tb_vec_packer;

    localparam int N    = 32;
    localparam int BITS = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BITS-1:0]   in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [N*BITS-1:0] out_vec;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [5:0]        out_count;

    int checks = 0;
    int errors = 0;

    vec_packer #(
        .N    (N),
        .BITS (BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [BITS-1:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 6'd0 || out_vec !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d vec_nonzero=%b, required 0/0/0",
                     out_valid, out_count, |out_vec);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_fill();
        logic [N*BITS-1:0] exp;
        int sum;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            exp[k*BITS +: BITS] = BITS'(k + 1);
            beat(BITS'(k + 1), 1'b0);
            if (k == N - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_early_valid: out_valid=%b after beat 31, required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 6'd32) begin
            errors++;
            $display("FAIL fill_valid: out_valid=%b count=%0d, required 1/32", out_valid, out_count);
        end
        checks++;
        if (out_vec !== exp) begin
            errors++;
            $display("FAIL fill_lanes: got %h required %h", out_vec, exp);
        end
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(out_vec[k*BITS +: BITS]);
        checks++;
        if (sum !== 528) begin
            errors++;
            $display("FAIL fill_sum: got %0d required 528", sum);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_taken: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [N*BITS-1:0] exp;
        logic [N*BITS-1:0] exp2;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp[k*BITS +: BITS] = BITS'(100 + k);
            beat(BITS'(100 + k), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: out_valid=%b, required 1", out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hAA;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready cycle %0d: in_ready=%b, required 0", c, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_vec !== exp) begin
                errors++;
                $display("FAIL bp_stable cycle %0d: valid=%b vec=%h required 1/%h",
                         c, out_valid, out_vec, exp);
            end
        end
        out_ready = 1'b1;
        in_data   = 32'h55;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_taken: out_valid=%b, required 0", out_valid);
        end
        exp2[BITS-1:0] = 32'h55;
        for (int k = 1; k < N; k++) begin
            exp2[k*BITS +: BITS] = BITS'(200 + k);
            beat(BITS'(200 + k), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_vec !== exp2) begin
            errors++;
            $display("FAIL bp_same_cycle_beat: valid=%b vec=%h required 1/%h", out_valid, out_vec, exp2);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [N*BITS-1:0] exp;
        int cyc = 0;
        int last_cyc = 0;
        int nvec = 0;
        out_ready = 1'b1;
        for (int j = 0; j < 3 * N; j++) begin
            beat(BITS'(1000 + j), 1'b0);
            cyc++;
            if (out_valid === 1'b1) begin
                for (int k = 0; k < N; k++) exp[k*BITS +: BITS] = BITS'(1000 + nvec * N + k);
                checks++;
                if (out_vec !== exp || out_count !== 6'd32) begin
                    errors++;
                    $display("FAIL stream_vec %0d: vec=%h count=%0d required %h/32",
                             nvec, out_vec, out_count, exp);
                end
                if (nvec > 0) begin
                    checks++;
                    if (cyc - last_cyc !== N) begin
                        errors++;
                        $display("FAIL stream_gap %0d: got %0d cycles required 32", nvec, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                nvec++;
            end
        end
        checks++;
        if (nvec !== 3) begin
            errors++;
            $display("FAIL stream_count: got %0d vectors required 3", nvec);
        end
        idle_cycle();
    endtask

    task automatic test_pad();
        logic [N*BITS-1:0] exp;
        out_ready = 1'b0;
        for (int b = 0; b < 10; b++) beat(32'd7, b == 9);
`ifdef VEC_PACKER_PAD_EN
        for (int k = 0; k < N; k++) exp[k*BITS +: BITS] = (k < 10) ? 32'd7 : 32'd0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 6'd10 || out_vec !== exp) begin
            errors++;
            $display("FAIL pad_short: valid=%b count=%0d vec=%h required 1/10/%h",
                     out_valid, out_count, out_vec, exp);
        end
`else
        begin
            int early = 0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL nopad_last_ignored: out_valid=%b, required 0", out_valid);
            end
            for (int b = 0; b < 22; b++) begin
                beat(32'd7, 1'b0);
                if (b < 21 && out_valid === 1'b1) early++;
            end
            checks++;
            if (early !== 0) begin
                errors++;
                $display("FAIL nopad_early: valid seen %0d times, required 0", early);
            end
            for (int k = 0; k < N; k++) exp[k*BITS +: BITS] = 32'd7;
            checks++;
            if (out_valid !== 1'b1 || out_count !== 6'd32 || out_vec !== exp) begin
                errors++;
                $display("FAIL nopad_full: valid=%b count=%0d vec=%h required 1/32/%h",
                         out_valid, out_count, out_vec, exp);
            end
        end
`endif
        out_ready = 1'b1;
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pad_taken: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [N*BITS-1:0] exp;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) beat(BITS'(32'h300 + k), 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_vec !== '0 || out_count !== 6'd0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b count=%0d vec_nonzero=%b, required 0/0/0",
                     out_valid, out_count, |out_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            exp[k*BITS +: BITS] = BITS'(32'h400 + k);
            beat(BITS'(32'h400 + k), 1'b0);
            if (k == N - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_early: out_valid=%b after 31 beats, required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_vec !== exp) begin
            errors++;
            $display("FAIL midreset_vec: valid=%b vec=%h required 1/%h", out_valid, out_vec, exp);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_pad();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
